// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: shared FSM encodings and default width for the serial subtractor
package serial_sub_pkg;
    localparam int SS_DEFAULT_N = 4;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } ss_state_e;
endpackage

// File: rtl/full_subtractor.sv
// full_subtractor: one-bit combinational subtractor cell
// Ports: a, b - operand bits; bin - borrow in; diff - difference bit; bout - borrow out
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);
    assign diff = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial unsigned subtractor, one bit per clock, LSB first
// Ports: clk, rst_n (sync, active-low), start - begin request sampled in IDLE,
//        a, b - operands captured on the accepting edge, busy - RUN or DONE,
//        done - one-cycle result-valid pulse, diff - (a-b) mod 2^N, borrow - a < b
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int N = SS_DEFAULT_N
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] diff,
    output logic         borrow
);
    localparam int CW = $clog2(N + 1);
    ss_state_e state_q, state_d;
    logic [N-1:0] a_q, a_d, b_q, b_d, diff_q, diff_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic borrow_q, borrow_d, busy_q, busy_d, done_q, done_d;
    logic bit_diff, bit_bout, last;
    full_subtractor u_fs (
        .a   (a_q[0]),
        .b   (b_q[0]),
        .bin (borrow_q),
        .diff(bit_diff),
        .bout(bit_bout)
    );
    assign last = cnt_q == CW'(N - 1);
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        diff_d   = diff_q;
        cnt_d    = cnt_q;
        borrow_d = borrow_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                state_d  = RUN;
                a_d      = a;
                b_d      = b;
                borrow_d = 1'b0;
                cnt_d    = '0;
                busy_d   = 1'b1;
            end
            RUN: begin
                // operands shift right so bit 0 always feeds the cell; result enters at the MSB
                a_d      = a_q >> 1;
                b_d      = b_q >> 1;
                diff_d   = {bit_diff, diff_q[N-1:1]};
                borrow_d = bit_bout;
                cnt_d    = cnt_q + CW'(1);
                state_d  = last ? DONE : RUN;
                done_d   = last;
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            diff_q   <= '0;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            diff_q   <= diff_d;
            cnt_q    <= cnt_d;
            borrow_q <= borrow_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end
    assign busy   = busy_q;
    assign done   = done_q;
    assign diff   = diff_q;
    assign borrow = borrow_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed and exhaustive check of serial_subtractor against a timestamp model
module tb_serial_subtractor;
    localparam int N = 4;
    logic clk = 1'b0;
    logic rst_n, start;
    logic [N-1:0] a, b, diff;
    logic busy, done, borrow;
    int total = 0, bad = 0;
    bit chk_en = 0;
    serial_subtractor #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .borrow(borrow)
    );
    always #5 clk = ~clk;
    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp_v);
        end
    endtask
    // model: an operation is a capture timestamp; busy spans edges cap..cap+N, done at cap+N
    int ecount = 0, cap = 0, ma = 0, mb = 0;
    bit active = 0, exp_busy = 0, exp_done = 0, exp_borrow = 0;
    int exp_diff = 0;
    always @(posedge clk) begin
        ecount++;
        if (!rst_n) begin
            active = 0;
            exp_diff = 0;
            exp_borrow = 0;
        end else if (start && (!active || ecount >= cap + N + 2)) begin
            active = 1;
            cap = ecount;
            ma = int'(a);
            mb = int'(b);
        end
        if (active && ecount == cap + N) begin
            exp_diff = (ma - mb) & ((1 << N) - 1);
            exp_borrow = ma < mb;
        end
        exp_busy = active && ecount >= cap && ecount <= cap + N;
        exp_done = active && ecount == cap + N;
    end
    always @(negedge clk) if (chk_en) begin
        check("model busy", busy, exp_busy);
        check("model done", done, exp_done);
        if (!exp_busy || exp_done) begin
            check("model diff", diff, exp_diff);
            check("model borrow", borrow, exp_borrow);
        end
    end
    task automatic op(input logic [N-1:0] ta, input logic [N-1:0] tb_v, input logic [N-1:0] ed,
                      input logic eb, input string nm);
        int lat = -1;
        a = ta;
        b = tb_v;
        start = 1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            start = 0;
            if (done) begin
                lat = i - 1;
                break;
            end
        end
        check({nm, " latency"}, lat, N);
        check({nm, " diff"}, diff, ed);
        check({nm, " borrow"}, borrow, eb);
        @(negedge clk);
    endtask
    initial begin
        int nb, nd, t1, t2;
        rst_n = 0;
        start = 1;
        a = 4'd9;
        b = 4'd3;
        repeat (2) @(negedge clk);
        chk_en = 1;
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset diff", diff, 0);
        check("reset borrow", borrow, 0);
        start = 0;
        rst_n = 1;
        @(negedge clk);
        a = 4'd9;
        b = 4'd3;
        start = 1;
        nb = 0;
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            start = 0;
            if (busy) nb++;
        end
        check("basic busy cycles", nb, 5);
        check("basic diff", diff, 6);
        check("basic borrow", borrow, 0);
        op(4'd9, 4'd3, 4'd6, 1'b0, "9-3");
        op(4'd3, 4'd9, 4'hA, 1'b1, "3-9");
        op(4'd0, 4'd1, 4'd15, 1'b1, "0-1");
        op(4'd15, 4'd15, 4'd0, 1'b0, "15-15");
        a = 4'd12;
        b = 4'd5;
        start = 1;
        nd = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            start = 0;
            if (i == 2) begin
                a = 4'd1;
                b = 4'd1;
                start = 1;
            end
            if (i == 3) begin
                a = 4'd15;
                b = 4'd0;
            end
            if (done) begin
                nd++;
                check("protect diff", diff, 7);
                check("protect borrow", borrow, 0);
            end
        end
        check("protect done count", nd, 1);
        a = 4'd7;
        b = 4'd2;
        start = 1;
        t1 = -1;
        t2 = -100;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (done && t1 < 0) begin
                t1 = i;
                check("b2b first diff", diff, 5);
                check("b2b first borrow", borrow, 0);
                a = 4'd2;
                b = 4'd7;
            end else if (done) begin
                t2 = i;
                start = 0;
                check("b2b second diff", diff, 11);
                check("b2b second borrow", borrow, 1);
                break;
            end
        end
        start = 0;
        check("b2b spacing", t2 - t1, 6);
        @(negedge clk);
        a = 4'd9;
        b = 4'd3;
        start = 1;
        @(negedge clk);
        start = 0;
        repeat (2) @(negedge clk);
        rst_n = 0;
        start = 1;
        @(negedge clk);
        rst_n = 1;
        start = 0;
        check("midrun busy", busy, 0);
        check("midrun done", done, 0);
        check("midrun diff", diff, 0);
        check("midrun borrow", borrow, 0);
        nd = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) nd++;
        end
        check("midrun no done", nd, 0);
        op(4'd9, 4'd3, 4'd6, 1'b0, "after reset 9-3");
        for (int x = 0; x < 16; x++)
            for (int y = 0; y < 16; y++)
                op(N'(x), N'(y), N'((x - y) & 15), x < y, "exhaustive");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The block SHALL have parameter N, default 4, giving the operand and result width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin a subtraction, sampled only in IDLE.
REQ-005 The block SHALL have port a, input, N bits: minuend, unsigned.
REQ-006 The block SHALL have port b, input, N bits: subtrahend, unsigned.
REQ-007 The block SHALL have port busy, output, 1 bit: high while in RUN or DONE.
REQ-008 The block SHALL have port done, output, 1 bit: one-cycle pulse marking valid results.
REQ-009 The block SHALL have port diff, output, N bits: (a - b) mod 2^N.
REQ-010 The block SHALL have port borrow, output, 1 bit: final borrow-out, 1 iff a < b unsigned.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-012 In IDLE with start=1 at edge k, the block SHALL capture a and b into internal shift registers, clear the borrow flop and the bit counter, and go to RUN.
REQ-013 Operands SHALL be sampled only at edge k; later changes on a and b SHALL have no effect.
REQ-014 In RUN, each edge SHALL process one bit, LSB first: d = ai^bi^bin, bout = (~ai&bi)|(~(ai^bi)&bin).
REQ-015 On each RUN edge, d SHALL shift into diff from the MSB end and bout SHALL be stored in the borrow flop.
REQ-016 The bit counter SHALL be ceil(log2(N+1)) bits wide, increment once per RUN edge, and never wrap.
REQ-017 After the N-th RUN edge (edge k+N), the state SHALL be DONE, diff SHALL hold the full result, borrow SHALL hold the final bout, and done SHALL be 1.
REQ-018 Latency from the capture edge to the done pulse SHALL be exactly N cycles, and start SHALL be re-accepted no earlier than edge k+N+2.
REQ-019 DONE SHALL go to IDLE unconditionally at the next edge, with done returning to 0.
REQ-020 diff and borrow SHALL hold their values until the next accepted start.
REQ-021 start in RUN or DONE SHALL be ignored, with no queuing and no restart.
REQ-022 Any start held continuously SHALL be accepted at each IDLE visit (back-to-back operation every N+2 cycles).
REQ-023 During RUN, diff SHALL show the partially shifted value and SHALL be treated as invalid until done.

Reset
REQ-024 rst_n=0 at an edge SHALL force state IDLE, busy=0, done=0, diff=0, borrow=0, and clear the counter and shift registers.
REQ-025 Reset SHALL take priority over start and over all FSM transitions.
REQ-026 Reset asserted mid-RUN SHALL abort the operation with no done pulse.
REQ-027 With rst_n=0 and start=1 at the same edge, start SHALL be ignored.

Structure
REQ-028 State encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the default width SHALL live in shared package serial_sub_pkg.
REQ-029 The per-bit logic SHALL be a single combinational sub-module full_subtractor, with ports a, b, bin, diff and bout, instantiated once.
REQ-030 All outputs SHALL be registered.

Verification (N=4)
REQ-031 Basic subtract: a=9, b=3, start for 1 cycle -> done exactly 4 cycles after the capture edge, diff=6, borrow=0, busy high for 5 cycles.
REQ-032 Negative result: a=3, b=9 -> diff=4'hA, borrow=1; edge cases a=0, b=1 -> diff=15, borrow=1; a=15, b=15 -> diff=0, borrow=0.
REQ-033 Busy and operand protection: start pulsed again 2 cycles after capture with a=1, b=1, and a/b changed during RUN -> ignored, result still from the original operands, one done pulse only.
REQ-034 Back-to-back: start held high across two operations (7-2, then 2-7) -> done pulses 6 cycles apart, results 5/0 then 11/1.
REQ-035 Reset mid-RUN: rst_n low for 1 cycle at RUN bit 2 -> no done, outputs 0, next start gives the correct result.
REQ-036 Exhaustive: all 256 (a,b) pairs -> diff and borrow match the reference model (a-b)&15 and (a<b).
